regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file with an integrated pending-write scoreboard, the successor to the single-write, two-read register file in the integer pipeline.
- Provides NRD combinational read ports, two prioritised write ports (ALU writeback and load writeback), register 0 hardwired to zero, and optional same-cycle write-to-read bypass.
- Writes commit on the rising edge, so the pipeline no longer needs a falling-edge write to resolve decode/writeback hazards.
- The scoreboard tracks registers with an outstanding producer so decode can stall.

---
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp.sv | 119 +++++++++++
 tb/tb_regfile_mp.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and scoreboard-set signals of the multi-port register file.
// The pipeline drives through the master modport; the register file uses the slave modport.
// Read port i uses rd_addr[i*AW +: AW], rd_data[i*W +: W] and rd_busy[i].
interface regfile_mp_if #(
  parameter int W   = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*W-1:0]  rd_data;
  logic [NRD-1:0]    rd_busy;
  // ALU writeback (lower priority)
  logic              we0;
  logic [AW-1:0]     waddr0;
  logic [W-1:0]      wdata0;
  // load writeback (higher priority)
  logic              we1;
  logic [AW-1:0]     waddr1;
  logic [W-1:0]      wdata1;
  // producer issued: mark destination pending
  logic              bset_en;
  logic [AW-1:0]     bset_addr;

  modport master (
    output rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1, bset_en, bset_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1, bset_en, bset_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2^AW x W register file with NRD combinational read ports, two
// prioritised rising-edge write ports (port 1 wins on collision), r0 hardwired
// to zero, and a per-register pending-write scoreboard.
// Optional macro RF_BYPASS_EN: same-cycle write data is forwarded to matching
// read ports, and their busy flag is suppressed.

// One read lane: stored-value mux plus optional write-forwarding compare.
module regfile_mp_rdport #(
  parameter int W    = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic [AW-1:0]             addr_i,
  input  logic [NREG-1:0][W-1:0]    mem_i,
  input  logic [NREG-1:0]           busy_i,
`ifdef RF_BYPASS_EN
  input  logic                      we0_i,
  input  logic [AW-1:0]             waddr0_i,
  input  logic [W-1:0]              wdata0_i,
  input  logic                      we1_i,
  input  logic [AW-1:0]             waddr1_i,
  input  logic [W-1:0]              wdata1_i,
`endif
  output logic [W-1:0]              data_o,
  output logic                      busy_o
);
  logic          nz;
  logic [W-1:0]  stored;

  assign nz     = (addr_i != '0);
  assign stored = nz ? mem_i[addr_i] : '0;

`ifdef RF_BYPASS_EN
  logic hit0, hit1;
  assign hit0 = nz && we0_i && (waddr0_i == addr_i);
  assign hit1 = nz && we1_i && (waddr1_i == addr_i);

  // forward in-flight write data; port 1 has priority, a hit means no stall
  always_comb begin
    data_o = stored;
    busy_o = nz & busy_i[addr_i];
    if (hit1)      data_o = wdata1_i;
    else if (hit0) data_o = wdata0_i;
    if (hit0 || hit1) busy_o = 1'b0;
  end
`else
  // stored state only
  always_comb begin
    data_o = stored;
    busy_o = nz & busy_i[addr_i];
  end
`endif
endmodule

module regfile_mp #(
  parameter int W   = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic         clk,
  input  logic         resetn,
  regfile_mp_if.slave  bus
);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0][W-1:0] mem_q, mem_d;
  logic [NREG-1:0]        busy_q, busy_d;
  logic [NRD-1:0][W-1:0]  rd_data_w;
  logic [NRD-1:0]         rd_busy_w;

  // next storage: port 0 first so a port-1 write to the same entry overrides it
  always_comb begin
    mem_d = mem_q;
    if (bus.we0 && (bus.waddr0 != '0)) mem_d[bus.waddr0] = bus.wdata0;
    if (bus.we1 && (bus.waddr1 != '0)) mem_d[bus.waddr1] = bus.wdata1;
    mem_d[0] = '0;
  end

  // next scoreboard: writes clear, then a new producer set overrides the clear
  always_comb begin
    busy_d = busy_q;
    if (bus.we0)     busy_d[bus.waddr0]    = 1'b0;
    if (bus.we1)     busy_d[bus.waddr1]    = 1'b0;
    if (bus.bset_en) busy_d[bus.bset_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // storage and scoreboard flops; async reset drops any write/set in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_mp_rdport #(.W(W), .AW(AW), .NREG(NREG)) u_rd (
      .addr_i   (bus.rd_addr[i*AW +: AW]),
      .mem_i    (mem_q),
      .busy_i   (busy_q),
`ifdef RF_BYPASS_EN
      .we0_i    (bus.we0),
      .waddr0_i (bus.waddr0),
      .wdata0_i (bus.wdata0),
      .we1_i    (bus.we1),
      .waddr1_i (bus.waddr1),
      .wdata1_i (bus.wdata1),
`endif
      .data_o   (rd_data_w[i]),
      .busy_o   (rd_busy_w[i])
    );
  end

  assign bus.rd_data = rd_data_w;
  assign bus.rd_busy = rd_busy_w;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table, hand sequences for bypass and
// mid-run reset, and randomized traffic against an array-based reference model.
module tb_regfile_mp;
  localparam int W = 32, AW = 5, NRD = 4, NREG = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.W(W), .AW(AW), .NRD(NRD)) rf();
  regfile_mp #(.W(W), .AW(AW), .NRD(NRD)) dut (.clk(clk), .resetn(resetn), .bus(rf));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [W-1:0] m_mem [NREG];
  bit           m_busy[NREG];

  typedef struct {
    logic                  we0;
    logic [AW-1:0]         wa0;
    logic [W-1:0]          wd0;
    logic                  we1;
    logic [AW-1:0]         wa1;
    logic [W-1:0]          wd1;
    logic                  bs;
    logic [AW-1:0]         ba;
    logic [NRD-1:0][AW-1:0] ra;
    logic [NRD-1:0][W-1:0]  ed;
    logic [NRD-1:0]         eb;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rf.we0 = 0; rf.waddr0 = '0; rf.wdata0 = '0;
    rf.we1 = 0; rf.waddr1 = '0; rf.wdata1 = '0;
    rf.bset_en = 0; rf.bset_addr = '0; rf.rd_addr = '0;
  endtask

  task automatic model_clear();
    for (int a = 0; a < NREG; a++) begin m_mem[a] = '0; m_busy[a] = 0; end
  endtask

  // architectural effect of one rising edge with the current inputs
  task automatic model_edge();
    if (rf.we0 && rf.waddr0 != 0) begin m_mem[rf.waddr0] = rf.wdata0; m_busy[rf.waddr0] = 0; end
    if (rf.we1 && rf.waddr1 != 0) begin m_mem[rf.waddr1] = rf.wdata1; m_busy[rf.waddr1] = 0; end
    if (rf.bset_en && rf.bset_addr != 0) m_busy[rf.bset_addr] = 1;
  endtask

  // advance one clock; inputs may change 1ns after the edge
  task automatic step();
    @(posedge clk);
    if (resetn) model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      logic [W-1:0]  ed;
      logic          eb;
      a  = rf.rd_addr[i*AW +: AW];
      ed = (a == 0) ? '0 : m_mem[a];
      eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef RF_BYPASS_EN
      if (a != 0 && ((rf.we1 && rf.waddr1 == a) || (rf.we0 && rf.waddr0 == a))) begin
        ed = (rf.we1 && rf.waddr1 == a) ? rf.wdata1 : rf.wdata0;
        eb = 1'b0;
      end
`endif
      chk($sformatf("%s p%0d a%0d data", tag, i, a), rf.rd_data[i*W +: W], ed);
      chk($sformatf("%s p%0d a%0d busy", tag, i, a), W'(rf.rd_busy[i]), W'(eb));
    end
  endtask

  // sweep all addresses on every port, expecting all-zero data and busy
  task automatic sweep_zero(input string tag);
    for (int g = 0; g < NREG; g++) begin
      for (int i = 0; i < NRD; i++) rf.rd_addr[i*AW +: AW] = AW'((g + i) % NREG);
      #1;
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("%s g%0d p%0d data", tag, g, i), rf.rd_data[i*W +: W], '0);
        chk($sformatf("%s g%0d p%0d busy", tag, g, i), W'(rf.rd_busy[i]), '0);
      end
    end
    rf.rd_addr = '0;
  endtask

  initial begin
    idle();
    model_clear();
    // directed rows: inputs applied for one edge, then read with idle writes
    tbl[0] = '{1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 5'd0,
               {5'd0, 5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000};
    tbl[1] = '{1, 5'd5, 32'h1111_1111, 1, 5'd5, 32'h2222_2222, 0, 5'd0,
               {5'd0, 5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h0, 32'h2222_2222}, 4'b0000};
    tbl[2] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7,
               {5'd0, 5'd0, 5'd7, 5'd5}, {32'h0, 32'h0, 32'h0, 32'h2222_2222}, 4'b0010};
    tbl[3] = '{0, 5'd0, 32'h0, 1, 5'd7, 32'h0000_0077, 0, 5'd0,
               {5'd0, 5'd7, 5'd0, 5'd0}, {32'h0, 32'h77, 32'h0, 32'h0}, 4'b0000};
    tbl[4] = '{1, 5'd9, 32'h0000_0099, 0, 5'd0, 32'h0, 1, 5'd9,
               {5'd9, 5'd0, 5'd7, 5'd0}, {32'h99, 32'h0, 32'h77, 32'h0}, 4'b1000};
    tbl[5] = '{1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 5'd0,
               {5'd0, 5'd0, 5'd2, 5'd1}, {32'h0, 32'h0, 32'h2, 32'h1}, 4'b0000};
    tbl[6] = '{1, 5'd30, 32'h1E, 1, 5'd31, 32'h1F, 0, 5'd0,
               {5'd31, 5'd30, 5'd2, 5'd1}, {32'h1F, 32'h1E, 32'h2, 32'h1}, 4'b0000};

    // reset state while held low, then after release
    #2;
    sweep_zero("rst_low");
    @(posedge clk); #1;
    resetn = 1'b1;
    sweep_zero("rst_rel");

    for (int r = 0; r < 7; r++) begin
      rf.we0 = tbl[r].we0; rf.waddr0 = tbl[r].wa0; rf.wdata0 = tbl[r].wd0;
      rf.we1 = tbl[r].we1; rf.waddr1 = tbl[r].wa1; rf.wdata1 = tbl[r].wd1;
      rf.bset_en = tbl[r].bs; rf.bset_addr = tbl[r].ba;
      step();
      idle();
      rf.rd_addr = tbl[r].ra;
      #2;
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("vec%0d p%0d data", r, i), rf.rd_data[i*W +: W], tbl[r].ed[i]);
        chk($sformatf("vec%0d p%0d busy", r, i), W'(rf.rd_busy[i]), W'(tbl[r].eb[i]));
      end
      step();
    end

    // bypass corner: addr 3 holds 0x33 and is pending when we0 rewrites it
    idle(); rf.we0 = 1; rf.waddr0 = 5'd3; rf.wdata0 = 32'h33; step();
    idle(); rf.bset_en = 1; rf.bset_addr = 5'd3; step();
    idle(); rf.we0 = 1; rf.waddr0 = 5'd3; rf.wdata0 = 32'hA5A5_0003;
    rf.rd_addr[0 +: AW] = 5'd3;
    #2;
`ifdef RF_BYPASS_EN
    chk("byp same-cycle data", rf.rd_data[0 +: W], 32'hA5A5_0003);
    chk("byp same-cycle busy", W'(rf.rd_busy[0]), '0);
`else
    chk("nobyp same-cycle data", rf.rd_data[0 +: W], 32'h33);
    chk("nobyp same-cycle busy", W'(rf.rd_busy[0]), W'(1'b1));
`endif
    step();
    idle(); rf.rd_addr[0 +: AW] = 5'd3;
    #2;
    chk("byp after-edge data", rf.rd_data[0 +: W], 32'hA5A5_0003);
    chk("byp after-edge busy", W'(rf.rd_busy[0]), '0);
    step();

    // randomized traffic against the model; small address window half the time
    for (int c = 0; c < 400; c++) begin
      int lim;
      lim = ($urandom_range(0, 1) == 1) ? 7 : NREG - 1;
      rf.we0 = 1'($urandom_range(0, 1)); rf.waddr0 = AW'($urandom_range(0, lim)); rf.wdata0 = $urandom;
      rf.we1 = 1'($urandom_range(0, 1)); rf.waddr1 = AW'($urandom_range(0, lim)); rf.wdata1 = $urandom;
      rf.bset_en = 1'($urandom_range(0, 1)); rf.bset_addr = AW'($urandom_range(0, lim));
      for (int i = 0; i < NRD; i++) rf.rd_addr[i*AW +: AW] = AW'($urandom_range(0, lim));
      #2;
      check_model($sformatf("rand%0d", c));
      step();
    end

    // mid-run reset with a write and set pending at the edge: both must be dropped
    idle();
    #3;
    resetn = 1'b0;
    model_clear();
    #1;
    sweep_zero("midrst_low");
    rf.we0 = 1; rf.waddr0 = 5'd4; rf.wdata0 = 32'hCAFE_0004;
    rf.bset_en = 1; rf.bset_addr = 5'd4;
    step();
    idle();
    resetn = 1'b1;
    sweep_zero("midrst_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
